shift_unit_pipelined: RTL and testbench
=======================================

# shift_unit_pipelined

Parametrised, pipelined multi-mode shifter for the ALU datapath: logical left, logical right and arithmetic right shifts of a WIDTH-bit operand, with optional rotate. One shift-amount bit is resolved per registered stage. A valid/ready handshake on both sides lets the ALU issue one operation per cycle and absorb downstream stalls. This block generalises the team's fixed 32-bit combinational arithmetic-right shifter into a clocked, width-generic unit with defined out-of-range behaviour.

## Interface
- WIDTH, 32: operand width; power of two, 8..64.
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation accepted when in_valid && in_ready.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right; see Configuration).
- X  input  WIDTH  operand.
- Y  input  WIDTH  shift amount, full-width unsigned.
- in_tag  input  TAG_W  user tag.
- out_valid  output  1  result available.
- out_ready  input  1  result consumed when out_valid && out_ready.
- Z  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the operation in Z.

## Operation
- L = log2(WIDTH) stages. Stage k (0..L-1) shifts by 2^k when amount bit k is set, otherwise passes data through.
- Out-of-range is decoded at acceptance: any Y bit at index L or above set means range = 1.
  - SLL/SRL with range = 1 produces Z = 0.
  - SRA with range = 1 produces Z = {WIDTH{X[WIDTH-1]}}.
  - ROR uses Y mod WIDTH and ignores range.
- SRA fills vacated bits with the sign bit captured at acceptance. SLL/SRL fill with 0.
- Y = 0 produces Z = X for every op.
- op, range and tag travel with the data through every stage.
- Each stage holds a valid bit. Bubbles flow through and are never compressed.

## Timing
- Global advance = !out_valid || out_ready. in_ready = advance, combinational from out_ready.
- When advance = 1, every stage loads from its predecessor and stage 0 loads the accepted input (or a bubble if no input is accepted).
- When advance = 0, all stages hold and Z/out_tag stay stable while out_valid = 1.
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+L (5 cycles for WIDTH=32), provided there is no stall.
- Throughput is 1 operation per cycle.
- Simultaneous accept and consume in the same cycle is legal with no loss.
- Reset value of every output: out_valid = 0, Z = 0, out_tag = 0. in_ready = 1 out of reset.
- Reset asserted mid-flight clears all stage valids immediately. In-flight operations are dropped and are not replayed.

## Configuration
- SHIFT_UNIT_ROTATE_EN defined: op 11 performs rotate right by Y mod WIDTH. Stage k wraps the shifted-out 2^k bits into the top.
- SHIFT_UNIT_ROTATE_EN undefined: op 11 is executed as SRL, including the range rule. No wrap muxes are generated.

## Structure
- Package shift_unit_pkg holds:
  - op encoding constants OP_SLL, OP_SRL, OP_SRA, OP_ROR;
  - a stage payload typedef {data, op, range, sign, amt, tag, valid}.
- Sub-module shift_unit_stage, parametrised by WIDTH and stage index K:
  - one conditional 2^k shift/rotate;
  - a payload register with enable = advance.
- The top level is a generate loop over L instances plus the range/handshake logic.

## Test plan
- SRA X=32'hffffffff, Y=16, out_ready=1 -> Z=32'hffffffff, out_valid exactly 5 cycles after accept.
- SRL X=32'haaaaaaaa, Y=1 -> Z=32'h55555555. SRA with the same X and Y -> Z=32'hd5555555.
- Range rule:
  - SRA X=32'h7fffffff, Y=32'hff -> Z=0.
  - SRA X=32'h80000000, Y=32'hffffffff -> Z=32'hffffffff.
  - SLL X=32'h1, Y=32 -> Z=0.
- ROR X=32'h1, Y=33:
  - with SHIFT_UNIT_ROTATE_EN -> Z=32'h80000000;
  - without it -> Z=0.
- Back-to-back 8 ops with tags 0..7 and out_ready toggling 1,0,0,1 -> results in order, tags match, no drops or duplicates, Z stable while stalled.
- Pulse rst_n low with 3 ops in flight -> out_valid=0 and Z=0 immediately. The next op after release returns after 5 cycles.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// Shared definitions for the pipelined shifter: op encodings and the payload
// that moves from stage to stage. Payload fields are sized for the largest
// supported configuration (WIDTH <= 64, TAG_W <= 16); each instance uses the
// low bits and keeps the rest at zero.
package shift_unit_pkg;

   localparam int unsigned OP_W       = 2;
   localparam int unsigned DATA_MAX_W = 64;
   localparam int unsigned AMT_MAX_W  = 6;
   localparam int unsigned TAG_MAX_W  = 16;

   localparam logic [OP_W-1:0] OP_SLL = 2'b00;
   localparam logic [OP_W-1:0] OP_SRL = 2'b01;
   localparam logic [OP_W-1:0] OP_SRA = 2'b10;
   localparam logic [OP_W-1:0] OP_ROR = 2'b11;

   typedef struct packed {
      logic [DATA_MAX_W-1:0] data;
      logic [OP_W-1:0]       op;
      logic                  range;
      logic                  sign;
      logic [AMT_MAX_W-1:0]  amt;
      logic [TAG_MAX_W-1:0]  tag;
      logic                  valid;
   } stage_payload_t;

endpackage

// File: rtl/shift_unit_stage.sv
// One pipeline stage: conditionally shifts (or rotates) by 2^K when amount
// bit K is set, then registers the whole payload while advance is high.
// Ports: clk, rst_n, advance (global load enable), d (payload in), q (payload out).
// SHIFT_UNIT_ROTATE_EN adds the wrap path for OP_ROR.
module shift_unit_stage
   import shift_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned K     = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           advance,
   input  stage_payload_t d,
   output stage_payload_t q
);

   localparam int unsigned       S         = 1 << K;
   localparam logic [WIDTH-1:0]  FILL_MASK = ~({WIDTH{1'b1}} >> S);

   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] shifted;
   stage_payload_t   nxt;

   assign din = d.data[WIDTH-1:0];

   // Conditional 2^K shift; SRA fills from the sign captured at acceptance
   always_comb begin
      shifted = din;
      if (d.amt[K]) begin
         case (d.op)
            OP_SLL:  shifted = din << S;
            OP_SRA:  shifted = (din >> S) | (FILL_MASK & {WIDTH{d.sign}});
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROR:  shifted = (din >> S) | (din << (WIDTH - S));
`endif
            default: shifted = din >> S;
         endcase
      end
   end

   always_comb begin
      nxt      = d;
      nxt.data = DATA_MAX_W'(shifted);
   end

   // Payload register; everything holds while the output is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (advance) begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/shift_unit_pipelined.sv
// Pipelined multi-mode shifter (SLL/SRL/SRA, optional ROR) with valid/ready
// on both sides. An entry register captures the decoded operation, then
// log2(WIDTH) stages each resolve one amount bit.
// Ports: clk, rst_n; in_valid/in_ready, op, X, Y, in_tag (request);
//        out_valid/out_ready, Z, out_tag (result).
// Macro SHIFT_UNIT_ROTATE_EN: op 11 rotates right by Y mod WIDTH; when
// undefined op 11 behaves exactly as SRL. TAG_W must not exceed 16.
module shift_unit_pipelined
   import shift_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Z,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned L = $clog2(WIDTH);

   logic           advance;
   logic           accept;
   logic           out_of_range;
   logic [1:0]     eff_op;
   stage_payload_t entry_d;
   stage_payload_t entry_q;
   stage_payload_t stage_q [L];
   logic           unused_tail;

   // Whole pipe moves together; a held result blocks new input
   assign advance  = !stage_q[L-1].valid || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;

   assign out_of_range = |(Y >> L);

`ifdef SHIFT_UNIT_ROTATE_EN
   assign eff_op = op;
`else
   assign eff_op = (op == OP_ROR) ? OP_SRL : op;
`endif

   // Decode at acceptance: out-of-range shifts are resolved here so the
   // stages only ever see in-range amounts
   always_comb begin
      entry_d = '0;
      if (accept) begin
         entry_d.valid = 1'b1;
         entry_d.op    = eff_op;
         entry_d.range = out_of_range;
         entry_d.sign  = X[WIDTH-1];
         entry_d.tag   = TAG_MAX_W'(in_tag);
         if (out_of_range && (eff_op != OP_ROR)) begin
            entry_d.data = ((eff_op == OP_SRA) && X[WIDTH-1]) ?
                           DATA_MAX_W'({WIDTH{1'b1}}) : '0;
            entry_d.amt  = '0;
         end else begin
            entry_d.data = DATA_MAX_W'(X);
            entry_d.amt  = AMT_MAX_W'(Y[L-1:0]);
         end
      end
   end

   // Entry register; loads a bubble when nothing is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q <= '0;
      end else if (advance) begin
         entry_q <= entry_d;
      end
   end

   for (genvar k = 0; k < L; k++) begin : g_stage
      stage_payload_t d_k;
      if (k == 0) begin : g_first
         assign d_k = entry_q;
      end else begin : g_next
         assign d_k = stage_q[k-1];
      end
      shift_unit_stage #(
         .WIDTH (WIDTH),
         .K     (k)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .advance (advance),
         .d       (d_k),
         .q       (stage_q[k])
      );
   end

   assign out_valid = stage_q[L-1].valid;
   assign Z         = WIDTH'(stage_q[L-1].data);
   assign out_tag   = TAG_W'(stage_q[L-1].tag);

   // Control fields that only matter inside the pipe end here
   assign unused_tail = ^stage_q[L-1];

endmodule

// File: tb/tb_shift_unit_pipelined.sv
// Self-checking bench for shift_unit_pipelined (WIDTH=32, TAG_W=4).
// Results are predicted by a plain-arithmetic reference of the shift rules.
module tb_shift_unit_pipelined;
   import shift_unit_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned TW = 4;
   localparam int unsigned L  = 5;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    op;
   logic [W-1:0]  X;
   logic [W-1:0]  Y;
   logic [TW-1:0] in_tag;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  Z;
   logic [TW-1:0] out_tag;

   int errors = 0;
   int checks = 0;

   shift_unit_pipelined #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .X         (X),
      .Y         (Y),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Z         (Z),
      .out_tag   (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: result of one operation straight from the shift rules
   function automatic logic [W-1:0] ref_shift(input logic [1:0] o_in,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] y);
      logic [1:0] o;
      o = o_in;
`ifdef SHIFT_UNIT_ROTATE_EN
      if (o_in == 2'b11) begin
         int unsigned n;
         n = int'(y % W);
         return (n == 0) ? x : ((x >> n) | (x << (W - n)));
      end
`else
      if (o_in == 2'b11) o = 2'b01;
`endif
      if (y >= W) return (o == 2'b10 && x[W-1]) ? '1 : '0;
      case (o)
         2'b00:   return x << y;
         2'b01:   return x >> y;
         default: return W'($signed(x) >>> y);
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = '0; X = '0; Y = '0; in_tag = '0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (Z !== '0) begin errors++; $display("FAIL reset_z: got %h expected 0", Z); end
      checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [1:0]   t_op [10] = '{OP_SRA, OP_SRL, OP_SRA, OP_SRA, OP_SRA,
                                  OP_SLL, OP_ROR, OP_SLL, OP_ROR, OP_SLL};
      logic [W-1:0] t_x  [10] = '{32'hffffffff, 32'haaaaaaaa, 32'haaaaaaaa, 32'h7fffffff, 32'h80000000,
                                  32'h1, 32'h1, 32'h12345678, 32'h12345678, 32'h1};
      logic [W-1:0] t_y  [10] = '{32'd16, 32'd1, 32'd1, 32'hff, 32'hffffffff,
                                  32'd32, 32'd33, 32'd0, 32'd0, 32'd31};
      logic [W-1:0] t_z  [10] = '{32'hffffffff, 32'h55555555, 32'hd5555555, 32'h0, 32'hffffffff,
                                  32'h0, 32'h0, 32'h12345678, 32'h12345678, 32'h80000000};
      int lat;
`ifdef SHIFT_UNIT_ROTATE_EN
      t_z[6] = 32'h80000000;
`endif
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         op = t_op[i]; X = t_x[i]; Y = t_y[i]; in_tag = TW'(i);
         in_valid = 1'b1; out_ready = 1'b1;
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d]: got %b expected 1", i, in_ready); end
         @(negedge clk);
         in_valid = 1'b0;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         checks++; if (lat != L) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, L); end
         checks++; if (Z !== t_z[i]) begin errors++; $display("FAIL dir_z[%0d]: got %h expected %h", i, Z, t_z[i]); end
         checks++; if (out_tag !== TW'(i)) begin errors++; $display("FAIL dir_tag[%0d]: got %h expected %h", i, out_tag, TW'(i)); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bit            rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0]    s_op [8];
      logic [W-1:0]  s_x [8];
      logic [W-1:0]  s_y [8];
      logic [W-1:0]  exp_z [$];
      logic [TW-1:0] exp_tag [$];
      logic [W-1:0]  held_z;
      logic [TW-1:0] held_tag;
      bit            stalled = 1'b0;
      int issued = 0, received = 0, cyc = 0;
      for (int i = 0; i < 8; i++) begin
         s_op[i] = 2'($urandom_range(0, 3));
         s_x[i]  = $urandom;
         s_y[i]  = (i % 3 == 0) ? $urandom : W'($urandom_range(0, W - 1));
      end
      held_z = '0; held_tag = '0;
      while (received < 8 && cyc < 200) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || Z !== held_z || out_tag !== held_tag) begin
               errors++; $display("FAIL b2b_stall_hold: got v=%b z=%h t=%h expected v=1 z=%h t=%h", out_valid, Z, out_tag, held_z, held_tag);
            end
         end
         out_ready = rdy_pat[cyc % 4];
         in_valid  = (issued < 8);
         if (issued < 8) begin
            op = s_op[issued]; X = s_x[issued]; Y = s_y[issued]; in_tag = TW'(issued);
         end
         #1;
         if (in_valid && in_ready) begin
            exp_z.push_back(ref_shift(s_op[issued], s_x[issued], s_y[issued]));
            exp_tag.push_back(TW'(issued));
            issued++;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_z.size() == 0) begin
               errors++; $display("FAIL b2b_spurious: got tag %h expected no result", out_tag);
            end else begin
               if (Z !== exp_z[0] || out_tag !== exp_tag[0]) begin
                  errors++; $display("FAIL b2b_result: got z=%h t=%h expected z=%h t=%h", Z, out_tag, exp_z[0], exp_tag[0]);
               end
               void'(exp_z.pop_front()); void'(exp_tag.pop_front());
            end
            received++;
         end
         stalled = out_valid && !out_ready;
         held_z = Z; held_tag = out_tag;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (received != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", received); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_random(input int n);
      logic [1:0]    c_op;
      logic [W-1:0]  c_x, c_y;
      logic [W-1:0]  exp_z [$];
      logic [TW-1:0] exp_tag [$];
      logic [W-1:0]  held_z;
      logic [TW-1:0] held_tag;
      bit stalled = 1'b0, have = 1'b0;
      int issued = 0, received = 0, cyc = 0;
      c_op = '0; c_x = '0; c_y = '0; held_z = '0; held_tag = '0;
      while (received < n && cyc < 5000) begin
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || Z !== held_z || out_tag !== held_tag) begin
               errors++; $display("FAIL rnd_stall_hold: got v=%b z=%h t=%h expected v=1 z=%h t=%h", out_valid, Z, out_tag, held_z, held_tag);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = 1'b0;
         if (issued < n) begin
            if (!have) begin
               c_op = 2'($urandom_range(0, 3));
               c_x  = $urandom;
               case ($urandom_range(0, 3))
                  0:       c_y = $urandom;
                  1:       c_y = W'($urandom_range(W, W + 8));
                  default: c_y = W'($urandom_range(0, W - 1));
               endcase
               have = 1'b1;
            end
            in_valid = ($urandom_range(0, 4) != 0);
            op = c_op; X = c_x; Y = c_y; in_tag = TW'(issued);
         end
         #1;
         if (in_valid && in_ready) begin
            exp_z.push_back(ref_shift(c_op, c_x, c_y));
            exp_tag.push_back(TW'(issued));
            issued++;
            have = 1'b0;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_z.size() == 0) begin
               errors++; $display("FAIL rnd_spurious: got tag %h expected no result", out_tag);
            end else begin
               if (Z !== exp_z[0] || out_tag !== exp_tag[0]) begin
                  errors++; $display("FAIL rnd_result: got z=%h t=%h expected z=%h t=%h", Z, out_tag, exp_z[0], exp_tag[0]);
               end
               void'(exp_z.pop_front()); void'(exp_tag.pop_front());
            end
            received++;
         end
         stalled = out_valid && !out_ready;
         held_z = Z; held_tag = out_tag;
         cyc++;
      end
      in_valid = 1'b0;
      checks++; if (received != n) begin errors++; $display("FAIL rnd_count: got %0d expected %0d", received, n); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_drain: got out_valid %b expected 0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      logic [1:0]   m_op [3] = '{OP_SLL, OP_SRL, OP_SRA};
      logic [W-1:0] m_x  [3] = '{32'h1, 32'h100, 32'h80000000};
      logic [W-1:0] m_y  [3] = '{32'd4, 32'd4, 32'd31};
      int lat;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         op = m_op[i]; X = m_x[i]; Y = m_y[i]; in_tag = TW'(4'ha + i); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (Z !== 32'h10 || out_tag !== 4'ha) begin errors++; $display("FAIL mid_head: got z=%h t=%h expected z=00000010 t=a", Z, out_tag); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
      checks++; if (Z !== '0) begin errors++; $display("FAIL mid_rst_z: got %h expected 0", Z); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      op = OP_SRL; X = 32'hf0000000; Y = 32'd8; in_tag = 4'h5; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (lat != L) begin errors++; $display("FAIL mid_latency: got %0d expected %0d", lat, L); end
      checks++; if (Z !== 32'h00f00000 || out_tag !== 4'h5) begin errors++; $display("FAIL mid_after: got z=%h t=%h expected z=00f00000 t=5", Z, out_tag); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_replay: got out_valid %b expected 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random(200);
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
